// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
package load_store_unit_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned STRB_W          = XLEN / 8;
    localparam int unsigned MEM_OP_WIDTH    = 1;
    localparam int unsigned LSU_STATE_WIDTH = 2;

    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_READ  = 1'b0;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_WRITE = 1'b1;

    typedef enum logic [LSU_STATE_WIDTH-1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Access captured at issue; store data and address are already bus-shaped.
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] strb;
        logic [1:0]        offset;
        logic              is_signed;
    } lsu_req_t;

    // Number of enabled byte lanes.
    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Aligns a raw bus word to the addressed lanes and extends it to XLEN.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [STRB_W-1:0] mask,
    input  logic              is_signed,
    input  logic [XLEN-1:0]   raw,
    output logic [XLEN-1:0]   rdata_c
);

    logic [XLEN-1:0] shifted;
    logic [2:0]      n_bytes;

    // Shift the addressed byte down to lane 0, then size/extend by lane count.
    always_comb begin
        shifted = raw >> {offset, 3'b000};
        n_bytes = popcount4(mask);
        rdata_c = shifted;
        case (n_bytes)
            3'd1:    rdata_c = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            3'd2:    rdata_c = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: rdata_c = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the core to a req/resp data bus.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    io_req_valid,
    input  logic [MEM_OP_WIDTH-1:0] io_req_op,
    input  logic [XLEN-1:0]         io_req_addr,
    input  logic [XLEN-1:0]         io_req_wdata,
    input  logic [STRB_W-1:0]       io_req_mask,
    input  logic                    io_req_signed,
    output logic                    io_dmiss,
    output logic [XLEN-1:0]         io_resp_rdata,
    output logic                    io_err,
    output logic                    bus_req_valid,
    input  logic                    bus_req_ready,
    output logic                    bus_req_we,
    output logic [XLEN-1:0]         bus_req_addr,
    output logic [XLEN-1:0]         bus_req_wdata,
    output logic [STRB_W-1:0]       bus_req_strb,
    input  logic                    bus_resp_valid,
    input  logic [XLEN-1:0]         bus_resp_rdata
);

    // Counter must be able to hold TIMEOUT_CYCLES itself (handshake on the last allowed cycle).
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] aligned_c;
    logic            expired_c;

    load_align u_load_align (
        .offset    (req_q.offset),
        .mask      (req_q.strb),
        .is_signed (req_q.is_signed),
        .raw       (bus_resp_rdata),
        .rdata_c   (aligned_c)
    );

    // Next-state, request capture, timeout and result update.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        expired_c = (cnt_q >= CNT_LAST);
        case (state_q)
            LSU_IDLE: begin
                cnt_d = '0;
                if (io_req_valid) begin
                    if (io_req_mask == '0) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d         = LSU_REQ;
                        req_d.we        = (io_req_op == MEM_OP_WRITE);
                        req_d.addr      = {io_req_addr[XLEN-1:2], 2'b00};
                        req_d.wdata     = io_req_wdata << {io_req_addr[1:0], 3'b000};
                        req_d.strb      = io_req_mask;
                        req_d.offset    = io_req_addr[1:0];
                        req_d.is_signed = io_req_signed;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_req_ready) begin
                    state_d = LSU_RESP;
                end else if (expired_c) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            LSU_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_resp_valid) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b0;
                    if (!req_q.we) begin
                        rdata_d = aligned_c;
                    end
                end else if (expired_c) begin
                    state_d = LSU_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stall is combinational so the core holds in the very cycle the access appears.
    assign io_dmiss      = ((state_q == LSU_IDLE) && io_req_valid)
                         || (state_q == LSU_REQ) || (state_q == LSU_RESP);
    assign io_resp_rdata = rdata_q;
    assign io_err        = err_q;
    assign bus_req_valid = (state_q == LSU_REQ);
    assign bus_req_we    = req_q.we;
    assign bus_req_addr  = req_q.addr;
    assign bus_req_wdata = req_q.wdata;
    assign bus_req_strb  = req_q.strb;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a transaction-level model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TMO = 4;

    logic                    clk;
    logic                    rst;
    logic                    io_req_valid;
    logic [MEM_OP_WIDTH-1:0] io_req_op;
    logic [31:0]             io_req_addr;
    logic [31:0]             io_req_wdata;
    logic [3:0]              io_req_mask;
    logic                    io_req_signed;
    logic                    io_dmiss;
    logic [31:0]             io_resp_rdata;
    logic                    io_err;
    logic                    bus_req_valid;
    logic                    bus_req_ready;
    logic                    bus_req_we;
    logic [31:0]             bus_req_addr;
    logic [31:0]             bus_req_wdata;
    logic [3:0]              bus_req_strb;
    logic                    bus_resp_valid;
    logic [31:0]             bus_resp_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_rdata = '0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .io_req_valid   (io_req_valid),
        .io_req_op      (io_req_op),
        .io_req_addr    (io_req_addr),
        .io_req_wdata   (io_req_wdata),
        .io_req_mask    (io_req_mask),
        .io_req_signed  (io_req_signed),
        .io_dmiss       (io_dmiss),
        .io_resp_rdata  (io_resp_rdata),
        .io_err         (io_err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_we     (bus_req_we),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wdata  (bus_req_wdata),
        .bus_req_strb   (bus_req_strb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load result from the lane rules: shift down, keep 1/2/4 bytes, extend arithmetically.
    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [1:0] off,
                                               input logic [3:0] mask, input logic sg);
        logic [31:0] sh;
        int          n;
        int          v;
        sh = word >> (8 * off);
        n  = $countones(mask);
        if (n == 1) begin
            v = int'(sh & 32'hFF);
            if (sg && v >= 128) v = v - 256;
        end else if (n == 2) begin
            v = int'(sh & 32'hFFFF);
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = int'(sh);
        end
        return 32'(v);
    endfunction

    // One access: the bus slave accepts after dr+1 request cycles and responds
    // in the (ds+1)-th cycle after the handshake.
    task automatic run_access(input logic [MEM_OP_WIDTH-1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask, input logic sg,
                              input int dr, input int ds, input logic [31:0] word,
                              input logic stale);
        int          busy, nreq, allowed, k, reqc, respc, dmc;
        logic        tmo, hs, done, exp_err;
        logic [31:0] exp_rdata;

        // Budget of TMO bus cycles; an accepted request always gets one response cycle.
        tmo = 1'b0;
        if (mask == 4'b0000) begin
            busy = 0;
            nreq = 0;
        end else if (dr + 1 > TMO) begin
            busy = TMO;
            nreq = TMO;
            tmo  = 1'b1;
        end else begin
            allowed = (TMO - (dr + 1) > 1) ? TMO - (dr + 1) : 1;
            nreq    = dr + 1;
            if (ds + 1 <= allowed) begin
                busy = dr + 1 + ds + 1;
            end else begin
                busy = dr + 1 + allowed;
                tmo  = 1'b1;
            end
        end
        exp_err = (mask == 4'b0000) || tmo;
        if (tmo)                                          exp_rdata = '0;
        else if (mask == 4'b0000 || op == MEM_OP_WRITE)   exp_rdata = m_rdata;
        else                                              exp_rdata = load_model(word, addr[1:0], mask, sg);

        @(negedge clk);
        io_req_valid  = 1'b1;
        io_req_op     = op;
        io_req_addr   = addr;
        io_req_wdata  = wdata;
        io_req_mask   = mask;
        io_req_signed = sg;
        #1;
        chk("dmiss_on_issue", 32'(io_dmiss), 32'd1);
        @(posedge clk);

        k = 0; reqc = 0; respc = 0; dmc = 1; hs = 1'b0; done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            io_req_addr    = $urandom();
            io_req_wdata   = $urandom();
            io_req_mask    = 4'($urandom());
            io_req_signed  = 1'($urandom());
            io_req_op      = MEM_OP_WIDTH'($urandom());
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            bus_resp_rdata = $urandom();
            #1;
            if (!io_dmiss) begin
                done = 1'b1;
            end else begin
                dmc++;
                if (bus_req_valid) begin
                    reqc++;
                    if (reqc == dr + 1) begin
                        bus_req_ready = 1'b1;
                        hs            = 1'b1;
                        chk("req_addr", bus_req_addr, addr & 32'hFFFF_FFFC);
                        chk("req_strb", 32'(bus_req_strb), 32'(mask));
                        chk("req_we", 32'(bus_req_we), 32'(op == MEM_OP_WRITE));
                        if (op == MEM_OP_WRITE)
                            chk("req_wdata", bus_req_wdata, wdata << (8 * addr[1:0]));
                        if (stale) bus_resp_valid = 1'b1;
                    end
                end else if (hs) begin
                    respc++;
                    if (respc == ds + 1) begin
                        bus_resp_valid = 1'b1;
                        bus_resp_rdata = word;
                    end
                end
            end
        end
        chk("completed", 32'(done), 32'd1);
        chk("dmiss_cycles", 32'(dmc), 32'(1 + busy));
        chk("req_cycles", 32'(reqc), 32'(nreq));
        chk("done_err", 32'(io_err), 32'(exp_err));
        chk("done_rdata", io_resp_rdata, exp_rdata);
        chk("done_bus_idle", 32'(bus_req_valid), 32'd0);
        m_rdata = exp_rdata;

        // io_req_valid is still high through DONE; no second request may start.
        @(negedge clk);
        chk("no_reissue", 32'(bus_req_valid), 32'd0);
        io_req_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        io_req_valid   = 1'b0;
        io_req_op      = MEM_OP_READ;
        io_req_addr    = '0;
        io_req_wdata   = '0;
        io_req_mask    = '0;
        io_req_signed  = 1'b0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = '0;

        #12;
        chk("rst_dmiss", 32'(io_dmiss), 32'd0);
        chk("rst_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_rdata", io_resp_rdata, 32'd0);
        chk("rst_err", 32'(io_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // LW 0x100: ready on 2nd request cycle, response next cycle.
        run_access(MEM_OP_READ, 32'h100, 32'h0, 4'b1111, 1'b0, 1, 0, 32'hDEAD_BEEF, 1'b0);
        // LB / LBU at 0x103.
        run_access(MEM_OP_READ, 32'h103, 32'h0, 4'b1000, 1'b1, 0, 0, 32'h80FF_FFFF, 1'b0);
        chk("lb_value", io_resp_rdata, 32'hFFFF_FF80);
        run_access(MEM_OP_READ, 32'h103, 32'h0, 4'b1000, 1'b0, 0, 1, 32'h80FF_FFFF, 1'b1);
        chk("lbu_value", io_resp_rdata, 32'h0000_0080);
        // SH 0x202; load result must stay untouched.
        run_access(MEM_OP_WRITE, 32'h202, 32'h0000_1234, 4'b1100, 1'b0, 0, 0, 32'h5555_5555, 1'b0);
        // Zero mask: immediate DONE with error.
        run_access(MEM_OP_READ, 32'h001, 32'h0, 4'b0000, 1'b1, 0, 0, 32'h0, 1'b0);
        // Slave never accepts: timeout.
        run_access(MEM_OP_READ, 32'h300, 32'h0, 4'b1111, 1'b0, 99, 0, 32'h0, 1'b0);
        // Restore a nonzero result before the reset test.
        run_access(MEM_OP_READ, 32'h104, 32'h0, 4'b0011, 1'b1, 0, 0, 32'h1234_8001, 1'b0);

        // Reset during RESP, then a stale response in IDLE.
        @(negedge clk);
        io_req_valid = 1'b1;
        io_req_op    = MEM_OP_READ;
        io_req_addr  = 32'h400;
        io_req_mask  = 4'b1111;
        @(negedge clk);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        io_req_valid  = 1'b0;
        rst           = 1'b0;
        #1;
        chk("rst_mid_dmiss", 32'(io_dmiss), 32'd0);
        chk("rst_mid_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_mid_rdata", io_resp_rdata, 32'd0);
        chk("rst_mid_addr", bus_req_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        #1;
        chk("stale_rdata", io_resp_rdata, 32'd0);
        chk("stale_dmiss", 32'(io_dmiss), 32'd0);
        chk("stale_err", 32'(io_err), 32'd0);
        chk("stale_valid", 32'(bus_req_valid), 32'd0);
        m_rdata = '0;

        // Randomized legal accesses.
        for (int i = 0; i < 40; i++) begin
            int          sz;
            logic [1:0]  off;
            logic [3:0]  m;
            logic [31:0] a;
            sz = int'($urandom_range(0, 2));
            if (sz == 0) begin
                off = 2'($urandom());
                m   = 4'd1 << off;
            end else if (sz == 1) begin
                off = {1'($urandom()), 1'b0};
                m   = 4'd3 << off;
            end else begin
                off = 2'd0;
                m   = 4'hF;
            end
            if ($urandom_range(0, 9) == 0) m = 4'b0000;
            a      = $urandom();
            a[1:0] = off;
            run_access(MEM_OP_WIDTH'($urandom()), a, $urandom(), m, 1'($urandom()),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                       $urandom(), 1'($urandom()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
